cache_refill_ctrl: RTL and testbench

- Miss-handling engine directly downstream of the cache tag stage. It consumes `miss`, `write_back`, `axi_raddr`, `axi_waddr` and `lru`, and returns the one-cycle `refresh` pulse that makes the tag stage install the new line.
- For a miss it optionally writes back the 16-word victim line as an AXI INCR burst, then refills the line with a 16-word AXI INCR burst read.
- Refill words are streamed into the cache data array; victim words are read from it.

---
 rtl/cache_refill_ctrl.sv | 173 +++++++++++++++++
 tb/tb_cache_refill_ctrl.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_refill_ctrl.sv
//============================================================================
// cache_refill_ctrl : miss engine - optional victim write-back, then line refill
// Revision: 1.0
//============================================================================
`default_nettype none

module cache_refill_ctrl #(
  parameter int LINE_WORDS = 16,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  // tag-stage interface
  input  logic                          miss,
  input  logic                          write_back,
  input  logic [ADDR_WIDTH-1:0]         axi_raddr,
  input  logic [ADDR_WIDTH-1:0]         axi_waddr,
  input  logic                          lru,
  output logic                          refresh,
  output logic                          busy,
  // data-array interface
  output logic                          victim_way,
  output logic [$clog2(LINE_WORDS)-1:0] wb_word,
  input  logic [DATA_WIDTH-1:0]         wb_rdata,
  output logic                          refill_we,
  output logic [$clog2(LINE_WORDS)-1:0] refill_word,
  output logic [DATA_WIDTH-1:0]         refill_wdata,
  // AXI read channels
  output logic [ADDR_WIDTH-1:0]         araddr,
  output logic [7:0]                    arlen,
  output logic                          arvalid,
  input  logic                          arready,
  input  logic [DATA_WIDTH-1:0]         rdata,
  input  logic                          rvalid,
  input  logic                          rlast,
  output logic                          rready,
  // AXI write channels
  output logic [ADDR_WIDTH-1:0]         awaddr,
  output logic [7:0]                    awlen,
  output logic                          awvalid,
  input  logic                          awready,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic [3:0]                    wstrb,
  output logic                          wlast,
  output logic                          wvalid,
  input  logic                          wready,
  input  logic                          bvalid,
  output logic                          bready
);

  localparam int               CNT_W     = $clog2(LINE_WORDS);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(LINE_WORDS - 1);
  localparam logic [7:0]       BURST_LEN = 8'(LINE_WORDS - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_AW   = 3'd1,
    S_W    = 3'd2,
    S_B    = 3'd3,
    S_AR   = 3'd4,
    S_R    = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   raddr_q, raddr_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic                    way_q, way_d;
  logic [CNT_W-1:0]        wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0]        rd_cnt_q, rd_cnt_d;

  // Refill termination is counted locally, so the last-beat flag carries no information.
  logic unused_rlast;
  assign unused_rlast = rlast;

  always_comb begin
    state_d  = state_q;
    raddr_d  = raddr_q;
    waddr_d  = waddr_q;
    way_d    = way_q;
    wb_cnt_d = wb_cnt_q;
    rd_cnt_d = rd_cnt_q;
    case (state_q)
      S_IDLE: begin
        if (miss) begin
          raddr_d  = axi_raddr;
          waddr_d  = axi_waddr;
          way_d    = lru;
          wb_cnt_d = '0;
          rd_cnt_d = '0;
          state_d  = write_back ? S_AW : S_AR;
        end
      end
      S_AW: begin
        if (awready) begin
          wb_cnt_d = '0;
          state_d  = S_W;
        end
      end
      S_W: begin
        if (wready) begin
          wb_cnt_d = wb_cnt_q + CNT_W'(1);
          if (wb_cnt_q == LAST_WORD) state_d = S_B;
        end
      end
      S_B: begin
        if (bvalid) state_d = S_AR;
      end
      S_AR: begin
        if (arready) begin
          rd_cnt_d = '0;
          state_d  = S_R;
        end
      end
      S_R: begin
        if (rvalid) begin
          rd_cnt_d = rd_cnt_q + CNT_W'(1);
          if (rd_cnt_q == LAST_WORD) state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      raddr_q  <= '0;
      waddr_q  <= '0;
      way_q    <= 1'b0;
      wb_cnt_q <= '0;
      rd_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      raddr_q  <= raddr_d;
      waddr_q  <= waddr_d;
      way_q    <= way_d;
      wb_cnt_q <= wb_cnt_d;
      rd_cnt_q <= rd_cnt_d;
    end
  end

  // Outputs decode straight from the state register; data fields are zeroed outside their phase.
  assign busy         = (state_q != S_IDLE);
  assign refresh      = (state_q == S_DONE);
  assign victim_way   = way_q;

  assign awvalid      = (state_q == S_AW);
  assign awaddr       = awvalid ? waddr_q : '0;
  assign awlen        = awvalid ? BURST_LEN : 8'd0;

  assign wvalid       = (state_q == S_W);
  assign wb_word      = wb_cnt_q;
  assign wdata        = wvalid ? wb_rdata : '0;
  assign wstrb        = wvalid ? 4'hF : 4'h0;
  assign wlast        = wvalid && (wb_cnt_q == LAST_WORD);

  assign bready       = (state_q == S_B);

  assign arvalid      = (state_q == S_AR);
  assign araddr       = arvalid ? raddr_q : '0;
  assign arlen        = arvalid ? BURST_LEN : 8'd0;

  assign rready       = (state_q == S_R);
  assign refill_we    = rready && rvalid;
  assign refill_word  = rd_cnt_q;
  assign refill_wdata = refill_we ? rdata : '0;

endmodule

`default_nettype wire

// File: tb/tb_cache_refill_ctrl.sv
// Bench for cache_refill_ctrl: an AXI slave / data-array model drives randomized
// traffic; each scenario compares captured bursts against the line contents it chose.
`default_nettype none

module tb_cache_refill_ctrl;

  localparam int LW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        miss, write_back, lru;
  logic [31:0] axi_raddr, axi_waddr;
  logic        refresh, busy, victim_way;
  logic [3:0]  wb_word, refill_word;
  logic [31:0] wb_rdata, refill_wdata;
  logic        refill_we;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [7:0]  arlen, awlen;
  logic        arvalid, arready, rvalid, rlast, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic [3:0]  wstrb;

  cache_refill_ctrl #(.LINE_WORDS(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .miss(miss), .write_back(write_back),
    .axi_raddr(axi_raddr), .axi_waddr(axi_waddr), .lru(lru),
    .refresh(refresh), .busy(busy), .victim_way(victim_way),
    .wb_word(wb_word), .wb_rdata(wb_rdata), .refill_we(refill_we),
    .refill_word(refill_word), .refill_wdata(refill_wdata),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rlast(rlast), .rready(rready),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready), .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  // Victim line in the data array and the line the memory returns on refill.
  logic [31:0] vic  [LW];
  logic [31:0] rmem [LW];
  assign wb_rdata = vic[wb_word];

  int n_checks = 0;
  int n_errors = 0;
  int mode;  // 0: all ready, 1: scripted backpressure, 2: random

  // Captured transaction record
  logic [31:0] ar_q[$], aw_q[$], wd_q[$], rd_q[$];
  logic [7:0]  arlen_q[$], awlen_q[$];
  logic [3:0]  ws_q[$], rw_q[$];
  bit          wl_q[$];
  int refresh_cnt, refresh_cyc, b_cnt, b_cyc, ar_cyc, vw_bad;

  // Drives one miss from IDLE to completion (or abort) as tag stage + AXI slave.
  task automatic drive_txn(input bit dirty, input logic [31:0] ra, input logic [31:0] wa,
                           input bit way, input int drop_beat, input int rst_beat);
    int  k, r_idx, b_delay, tail, ar_wait, aw_wait, rgap;
    bit  ar_done, b_pend, fin, aborted;
    ar_q.delete(); aw_q.delete(); wd_q.delete(); rd_q.delete();
    arlen_q.delete(); awlen_q.delete(); ws_q.delete(); rw_q.delete(); wl_q.delete();
    refresh_cnt = 0; refresh_cyc = -1; b_cnt = 0; b_cyc = -1; ar_cyc = -1; vw_bad = 0;
    k = 0; r_idx = 0; b_delay = 0; tail = 0; ar_wait = 0; aw_wait = 0; rgap = 0;
    ar_done = 0; b_pend = 0; fin = 0; aborted = 0;
    while (!fin) begin
      if (rst_beat >= 0 && ar_done && r_idx == rst_beat) begin
        rst = 1'b0; miss = 1'b0; write_back = 1'b0;
        arready = 1'b0; awready = 1'b0; wready = 1'b0;
        rvalid = 1'b0; rlast = 1'b0; bvalid = 1'b0;
        aborted = 1; fin = 1;
      end else begin
        miss       = (refresh_cnt == 0) && !(drop_beat >= 0 && r_idx >= drop_beat);
        write_back = miss && dirty;
        // Launch-time values only on the first cycle; later values must not matter.
        axi_raddr  = (k == 0) ? ra : $urandom;
        axi_waddr  = (k == 0) ? wa : $urandom;
        lru        = (k == 0) ? way : 1'($urandom_range(0, 1));
        case (mode)
          0: begin arready = 1'b1; awready = 1'b1; wready = 1'b1; end
          1: begin
            arready = (ar_wait >= 5);
            awready = (aw_wait >= 2);
            wready  = (k % 4 == 0) || (k % 4 == 3);
          end
          default: begin
            arready = 1'($urandom_range(0, 1));
            awready = 1'($urandom_range(0, 1));
            wready  = 1'($urandom_range(0, 1));
          end
        endcase
        if (ar_done && r_idx < LW) begin
          case (mode)
            0:       rvalid = 1'b1;
            1:       rvalid = (rgap % 3 == 0);
            default: rvalid = ($urandom_range(0, 3) != 0);
          endcase
          rgap++;
        end else begin
          rvalid = 1'b0;
        end
        rdata = rvalid ? rmem[r_idx] : $urandom;
        rlast = rvalid && (r_idx == LW - 1);
        if (b_pend) begin
          bvalid = (b_delay == 0);
          if (b_delay > 0) b_delay--;
        end else begin
          bvalid = 1'b0;
        end
        #1;
        if (arvalid && arready) begin
          ar_q.push_back(araddr); arlen_q.push_back(arlen); ar_done = 1; ar_cyc = k;
        end else if (arvalid) ar_wait++;
        if (awvalid && awready) begin
          aw_q.push_back(awaddr); awlen_q.push_back(awlen);
        end else if (awvalid) aw_wait++;
        if (wvalid && wready) begin
          wd_q.push_back(wdata); wl_q.push_back(wlast); ws_q.push_back(wstrb);
          if (wlast) begin
            b_pend  = 1;
            b_delay = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
          end
        end
        if (bvalid && bready) begin b_pend = 0; b_cnt++; b_cyc = k; end
        if (rvalid && rready) r_idx++;
        if (refill_we) begin rw_q.push_back(refill_word); rd_q.push_back(refill_wdata); end
        if (busy && victim_way !== way) vw_bad++;
        if (refresh) begin
          refresh_cnt++;
          if (refresh_cyc < 0) refresh_cyc = k;
        end
        if (refresh_cnt > 0) begin
          tail++;
          if (tail > 6) fin = 1;
        end
        k++;
        if (k > 800 && !fin) begin
          n_checks++; n_errors++;
          $display("FAIL txn_timeout: no refresh after %0d cycles, required within 800", k);
          fin = 1;
        end
      end
      if (!aborted) @(negedge clk);
    end
  endtask

  // Protocol monitor: stalled channels must hold, refill strobe follows accepted beats.
  bit          p_aw, p_ar, p_w;
  logic [31:0] p_awaddr, p_araddr, p_wdata;
  logic [3:0]  p_wword;
  logic        p_wlast;
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      p_aw = 0; p_ar = 0; p_w = 0;
    end else begin
      if (p_aw) begin
        n_checks++;
        if (!awvalid || awaddr !== p_awaddr) begin
          n_errors++;
          $display("FAIL aw_hold: awvalid=%b awaddr=%h, required 1 %h", awvalid, awaddr, p_awaddr);
        end
      end
      if (p_ar) begin
        n_checks++;
        if (!arvalid || araddr !== p_araddr) begin
          n_errors++;
          $display("FAIL ar_hold: arvalid=%b araddr=%h, required 1 %h", arvalid, araddr, p_araddr);
        end
      end
      if (p_w) begin
        n_checks++;
        if (!wvalid || wdata !== p_wdata || wb_word !== p_wword || wlast !== p_wlast) begin
          n_errors++;
          $display("FAIL w_hold: v=%b data=%h word=%0d last=%b, required 1 %h %0d %b",
                   wvalid, wdata, wb_word, wlast, p_wdata, p_wword, p_wlast);
        end
      end
      if (rvalid || refill_we) begin
        n_checks++;
        if (refill_we !== (rvalid && rready)) begin
          n_errors++;
          $display("FAIL refill_we: got %b with rvalid=%b rready=%b, required %b",
                   refill_we, rvalid, rready, rvalid && rready);
        end
      end
      p_aw = awvalid && !awready; p_awaddr = awaddr;
      p_ar = arvalid && !arready; p_araddr = araddr;
      p_w  = wvalid && !wready;   p_wdata = wdata; p_wword = wb_word; p_wlast = wlast;
    end
  end

  task automatic fill_lines(input bit ramp);
    for (int i = 0; i < LW; i++) begin
      vic[i]  = $urandom;
      rmem[i] = ramp ? 32'h100 + i : $urandom;
    end
  endtask

  task automatic test_reset();
    fill_lines(0);
    miss = 1'b1; write_back = 1'b1; lru = 1'b1;
    axi_raddr = 32'h1234_5640; axi_waddr = 32'h0000_2200;
    arready = 1'b1; awready = 1'b1; wready = 1'b1; rvalid = 1'b1; rlast = 1'b0;
    bvalid = 1'b1; rdata = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({busy, refresh, victim_way, wb_word, refill_we, refill_word, refill_wdata, araddr, arlen,
         arvalid, rready, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs: busy=%b arv=%b awv=%b wv=%b wdata=%h rfw=%b, required all 0",
               busy, arvalid, awvalid, wvalid, wdata, refill_we);
    end
    miss = 1'b0; write_back = 1'b0; rvalid = 1'b0; bvalid = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || wb_word !== 4'd0 || refill_word !== 4'd0) begin
      n_errors++;
      $display("FAIL reset_idle: busy=%b wb_word=%0d refill_word=%0d, required 0 0 0",
               busy, wb_word, refill_word);
    end
  endtask

  task automatic test_clean_miss();
    int bad;
    mode = 0; fill_lines(1);
    drive_txn(0, 32'h1FC0_0040, 32'h0000_3F00, 1'b0, -1, -1);
    n_checks++;
    if (ar_q.size() != 1 || ar_q[0] !== 32'h1FC0_0040 || arlen_q[0] !== 8'd15) begin
      n_errors++;
      $display("FAIL clean_ar: %0d bursts, first addr %h len %0d, required 1 at 1fc00040 len 15",
               ar_q.size(), ar_q.size() > 0 ? ar_q[0] : 32'h0, arlen_q.size() > 0 ? arlen_q[0] : 8'h0);
    end
    bad = 0;
    if (rd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++) if (rw_q[i] !== i[3:0] || rd_q[i] !== 32'h100 + i) bad++;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL clean_refill: %0d beats, %0d bad, required 16 beats words 0..15 data 0x100+i",
               rd_q.size(), bad);
    end
    n_checks++;
    if (aw_q.size() != 0 || wd_q.size() != 0) begin
      n_errors++;
      $display("FAIL clean_no_write: aw=%0d w=%0d, required 0 0", aw_q.size(), wd_q.size());
    end
    n_checks++;
    if (refresh_cnt != 1 || refresh_cyc != 18) begin
      n_errors++;
      $display("FAIL clean_latency: refresh count %0d at cycle %0d, required 1 at 18",
               refresh_cnt, refresh_cyc);
    end
  endtask

  task automatic test_dirty_miss();
    int bad;
    mode = 0; fill_lines(0);
    drive_txn(1, 32'h8000_0F80, 32'h0000_1240, 1'b1, -1, -1);
    n_checks++;
    if (aw_q.size() != 1 || aw_q[0] !== 32'h0000_1240 || awlen_q[0] !== 8'd15) begin
      n_errors++;
      $display("FAIL dirty_aw: %0d bursts, first addr %h, required 1 at 00001240 len 15",
               aw_q.size(), aw_q.size() > 0 ? aw_q[0] : 32'h0);
    end
    bad = 0;
    if (wd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++)
      if (wd_q[i] !== vic[i] || wl_q[i] !== (i == LW - 1) || ws_q[i] !== 4'hF) bad++;
    n_checks++;
    if (bad != 0) begin
      n_errors++;
      $display("FAIL dirty_wbeats: %0d beats, %0d bad, required 16 victim words, wlast on 15 only",
               wd_q.size(), bad);
    end
    n_checks++;
    if (b_cnt != 1 || ar_q.size() != 1 || ar_cyc <= b_cyc || ar_q[0] !== 32'h8000_0F80) begin
      n_errors++;
      $display("FAIL dirty_b_then_ar: b=%0d ar=%0d ar_cyc=%0d b_cyc=%0d, required 1 1 with ar after b",
               b_cnt, ar_q.size(), ar_cyc, b_cyc);
    end
    bad = 0;
    if (rd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++) if (rw_q[i] !== i[3:0] || rd_q[i] !== rmem[i]) bad++;
    n_checks++;
    if (bad != 0 || vw_bad != 0) begin
      n_errors++;
      $display("FAIL dirty_refill: %0d beats, %0d bad, %0d way errors, required 16 0 0",
               rd_q.size(), bad, vw_bad);
    end
    n_checks++;
    if (refresh_cnt != 1 || refresh_cyc != 36) begin
      n_errors++;
      $display("FAIL dirty_latency: refresh count %0d at cycle %0d, required 1 at 36",
               refresh_cnt, refresh_cyc);
    end
  endtask

  task automatic test_backpressure();
    int bad;
    mode = 1; fill_lines(0);
    drive_txn(1, 32'h0040_0100, 32'h0090_07C0, 1'b0, -1, -1);
    bad = 0;
    if (wd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++) if (wd_q[i] !== vic[i] || wl_q[i] !== (i == LW - 1)) bad++;
    n_checks++;
    if (bad != 0 || aw_q.size() != 1 || aw_q[0] !== 32'h0090_07C0) begin
      n_errors++;
      $display("FAIL bp_write: %0d beats %0d bad, aw=%0d, required 16 0 1", wd_q.size(), bad, aw_q.size());
    end
    bad = 0;
    if (rd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++) if (rw_q[i] !== i[3:0] || rd_q[i] !== rmem[i]) bad++;
    n_checks++;
    if (bad != 0 || ar_q.size() != 1 || ar_q[0] !== 32'h0040_0100 || refresh_cnt != 1) begin
      n_errors++;
      $display("FAIL bp_refill: %0d beats %0d bad, ar=%0d, refresh=%0d, required 16 0 1 1",
               rd_q.size(), bad, ar_q.size(), refresh_cnt);
    end
  endtask

  task automatic test_flush_mid_refill();
    int bad;
    mode = 0; fill_lines(0);
    drive_txn(0, 32'h0000_0A00, 32'h0, 1'b1, 6, -1);
    bad = 0;
    if (rd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++) if (rw_q[i] !== i[3:0] || rd_q[i] !== rmem[i]) bad++;
    n_checks++;
    if (bad != 0 || refresh_cnt != 1) begin
      n_errors++;
      $display("FAIL flush_refill: %0d beats %0d bad, refresh=%0d, required 16 0 1",
               rd_q.size(), bad, refresh_cnt);
    end
  endtask

  task automatic test_reset_mid_burst();
    int bad;
    mode = 0; fill_lines(0);
    drive_txn(0, 32'h0000_5540, 32'h0, 1'b1, -1, 8);
    #1;
    n_checks++;
    if ({busy, refresh, victim_way, wb_word, refill_we, refill_word, refill_wdata, araddr, arlen,
         arvalid, rready, awaddr, awlen, awvalid, wdata, wstrb, wlast, wvalid, bready} !== '0) begin
      n_errors++;
      $display("FAIL rst_async: busy=%b rready=%b word=%0d way=%b, required all 0",
               busy, rready, refill_word, victim_way);
    end
    n_checks++;
    if (rd_q.size() != 8 || refresh_cnt != 0) begin
      n_errors++;
      $display("FAIL rst_abort: %0d beats refresh=%0d, required 8 0", rd_q.size(), refresh_cnt);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if (busy !== 1'b0 || arvalid !== 1'b0) begin
      n_errors++;
      $display("FAIL rst_idle: busy=%b arvalid=%b, required 0 0", busy, arvalid);
    end
    fill_lines(0);
    drive_txn(0, 32'h0000_5580, 32'h0, 1'b0, -1, -1);
    bad = 0;
    if (rd_q.size() != LW) bad = 99;
    else for (int i = 0; i < LW; i++) if (rw_q[i] !== i[3:0] || rd_q[i] !== rmem[i]) bad++;
    n_checks++;
    if (bad != 0 || refresh_cnt != 1 || refresh_cyc != 18) begin
      n_errors++;
      $display("FAIL rst_restart: %0d beats %0d bad, refresh=%0d at %0d, required 16 0 1 at 18",
               rd_q.size(), bad, refresh_cnt, refresh_cyc);
    end
  endtask

  task automatic test_no_retrigger();
    mode = 0; fill_lines(0);
    drive_txn(1, 32'h0000_7000, 32'h0000_6000, 1'b0, -1, -1);
    n_checks++;
    if (ar_q.size() != 1 || aw_q.size() != 1 || refresh_cnt != 1 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL no_retrigger: ar=%0d aw=%0d refresh=%0d busy=%b, required 1 1 1 0",
               ar_q.size(), aw_q.size(), refresh_cnt, busy);
    end
  endtask

  task automatic test_random();
    int bad;
    bit dirty, way;
    logic [31:0] ra, wa;
    mode = 2;
    for (int it = 0; it < 10; it++) begin
      fill_lines(0);
      dirty = 1'($urandom_range(0, 1));
      way   = 1'($urandom_range(0, 1));
      ra    = $urandom & 32'hFFFF_FFC0;
      wa    = $urandom & 32'hFFFF_FFC0;
      drive_txn(dirty, ra, wa, way, -1, -1);
      bad = 0;
      if (dirty) begin
        if (wd_q.size() != LW || aw_q.size() != 1 || b_cnt != 1) bad = 99;
        else begin
          if (aw_q[0] !== wa) bad++;
          for (int i = 0; i < LW; i++) if (wd_q[i] !== vic[i] || wl_q[i] !== (i == LW - 1)) bad++;
        end
      end else if (wd_q.size() != 0 || aw_q.size() != 0 || b_cnt != 0) bad = 99;
      n_checks++;
      if (bad != 0) begin
        n_errors++;
        $display("FAIL rand_write[%0d]: dirty=%b aw=%0d w=%0d b=%0d bad=%0d, required %0d %0d %0d 0",
                 it, dirty, aw_q.size(), wd_q.size(), b_cnt, bad, dirty, dirty ? LW : 0, dirty);
      end
      bad = 0;
      if (rd_q.size() != LW || ar_q.size() != 1) bad = 99;
      else begin
        if (ar_q[0] !== ra) bad++;
        for (int i = 0; i < LW; i++) if (rw_q[i] !== i[3:0] || rd_q[i] !== rmem[i]) bad++;
      end
      n_checks++;
      if (bad != 0 || refresh_cnt != 1 || vw_bad != 0) begin
        n_errors++;
        $display("FAIL rand_refill[%0d]: ar=%0d beats=%0d bad=%0d refresh=%0d way_err=%0d, required 1 16 0 1 0",
                 it, ar_q.size(), rd_q.size(), bad, refresh_cnt, vw_bad);
      end
    end
  endtask

  initial begin
    miss = 1'b0; write_back = 1'b0; lru = 1'b0; axi_raddr = '0; axi_waddr = '0;
    arready = 1'b0; awready = 1'b0; wready = 1'b0; rvalid = 1'b0; rlast = 1'b0;
    bvalid = 1'b0; rdata = '0;
    @(negedge clk);
    test_reset();
    test_clean_miss();
    test_dirty_miss();
    test_backpressure();
    test_flush_mid_refill();
    test_reset_mid_burst();
    test_no_retrigger();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
